multi_cycle_ctrl: RTL and testbench

Moore control FSM for the multicycle MIPS datapath. It drives every datapath control input (IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA/B, PCSource, PCWrite, PCWriteCond, Branch, ALU_operation) and the memory request lines. It consumes the latched instruction, the ALU zero flag and MIO_ready. It sits directly upstream of the datapath and beside the memory/IO bus.

---
 rtl/ctrl_pkg.sv | 129 ++++++++++++
 rtl/multi_cycle_ctrl_if.sv | 37 +++
 rtl/alu_ctrl_dec.sv | 25 ++
 rtl/multi_cycle_ctrl.sv | 86 ++++++++
 tb/tb_multi_cycle_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// funct codes, ALU operation codes and the per-state output decode.
package ctrl_pkg;

    localparam int unsigned STATE_W = 4;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [STATE_W-1:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_LW    = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EX_R     = 4'd6,
        S_WB_R     = 4'd7,
        S_EX_BEQ   = 4'd8,
        S_EX_J     = 4'd9,
        S_EX_I     = 4'd10,
        S_WB_I     = 4'd11
    } state_t;

    typedef struct packed {
        logic       IorD;
        logic       IRWrite;
        logic [1:0] RegDst;
        logic       RegWrite;
        logic [1:0] MemtoReg;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] PCSource;
        logic       PCWrite;
        logic       PCWriteCond;
        logic       Branch;
        logic [2:0] ALU_operation;
        logic       MemRW;
        logic       CPU_MIO;
    } ctrl_out_t;

    function automatic ctrl_out_t ctrl_decode(input state_t s, input logic [2:0] alu_r,
                                              input logic is_slti);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_IF: begin
                o.CPU_MIO       = 1'b1;
                o.IRWrite       = 1'b1;
                o.ALUSrcB       = 2'b01;
                o.ALU_operation = ALU_ADD;
                o.PCWrite       = 1'b1;
            end
            S_ID: begin
                o.ALUSrcB       = 2'b11;
                o.ALU_operation = ALU_ADD;
            end
            S_EX_R: begin
                o.ALUSrcA       = 1'b1;
                o.ALU_operation = alu_r;
            end
            S_WB_R: begin
                o.RegDst   = 2'b01;
                o.RegWrite = 1'b1;
            end
            S_MEM_ADDR: begin
                o.ALUSrcA       = 1'b1;
                o.ALUSrcB       = 2'b10;
                o.ALU_operation = ALU_ADD;
            end
            S_MEM_RD: begin
                o.CPU_MIO = 1'b1;
                o.IorD    = 1'b1;
            end
            S_WB_LW: begin
                o.MemtoReg = 2'b01;
                o.RegWrite = 1'b1;
            end
            S_MEM_WR: begin
                o.CPU_MIO = 1'b1;
                o.IorD    = 1'b1;
                o.MemRW   = 1'b1;
            end
            S_EX_BEQ: begin
                o.ALUSrcA       = 1'b1;
                o.ALU_operation = ALU_SUB;
                o.PCWriteCond   = 1'b1;
                o.Branch        = 1'b1;
                o.PCSource      = 2'b01;
            end
            S_EX_J: begin
                o.PCSource = 2'b10;
                o.PCWrite  = 1'b1;
            end
            S_EX_I: begin
                o.ALUSrcA       = 1'b1;
                o.ALUSrcB       = 2'b10;
                o.ALU_operation = is_slti ? ALU_SLT : ALU_ADD;
            end
            S_WB_I: begin
                o.RegWrite = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
interface multi_cycle_ctrl_if;

    logic [31:0]                 Inst;
    logic                        zero;
    logic                        MIO_ready;
    logic                        IorD;
    logic                        IRWrite;
    logic [1:0]                  RegDst;
    logic                        RegWrite;
    logic [1:0]                  MemtoReg;
    logic                        ALUSrcA;
    logic [1:0]                  ALUSrcB;
    logic [1:0]                  PCSource;
    logic                        PCWrite;
    logic                        PCWriteCond;
    logic                        Branch;
    logic [2:0]                  ALU_operation;
    logic                        MemRW;
    logic                        CPU_MIO;
    logic [ctrl_pkg::STATE_W-1:0] state;

    modport master (
        input  Inst, zero, MIO_ready,
        output IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
               PCSource, PCWrite, PCWriteCond, Branch, ALU_operation, MemRW,
               CPU_MIO, state
    );

    modport slave (
        output Inst, zero, MIO_ready,
        input  IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
               PCSource, PCWrite, PCWriteCond, Branch, ALU_operation, MemRW,
               CPU_MIO, state
    );

endinterface

// File: rtl/alu_ctrl_dec.sv
// R-type funct decoder: ALU operation code plus a flag for supported functs.
module alu_ctrl_dec
    import ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_code,
    output logic       o_valid
);

    always_comb begin
        o_alu_code = ALU_ADD;
        o_valid    = 1'b1;
        case (i_funct)
            FN_ADD:  o_alu_code = ALU_ADD;
            FN_SUB:  o_alu_code = ALU_SUB;
            FN_AND:  o_alu_code = ALU_AND;
            FN_OR:   o_alu_code = ALU_OR;
            FN_XOR:  o_alu_code = ALU_XOR;
            FN_NOR:  o_alu_code = ALU_NOR;
            FN_SLT:  o_alu_code = ALU_SLT;
            default: o_valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath.
module multi_cycle_ctrl
    import ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    multi_cycle_ctrl_if.master bus
);

    state_t    r_state;
    ctrl_out_t r_out;
    state_t    w_next;
    logic [5:0] w_opcode;
    logic [2:0] w_alu_code;
    logic       w_funct_ok;
    logic       w_is_slti;
    logic       w_unused;

    assign w_opcode  = bus.Inst[31:26];
    assign w_is_slti = (w_opcode == OP_SLTI);
    assign w_unused  = ^{bus.zero, bus.Inst[25:6]};

    alu_ctrl_dec u_alu_ctrl_dec (
        .i_funct    (bus.Inst[5:0]),
        .o_alu_code (w_alu_code),
        .o_valid    (w_funct_ok)
    );

    always_comb begin
        w_next = S_IF;
        case (r_state)
            S_IF:       w_next = bus.MIO_ready ? S_ID : S_IF;
            S_ID: begin
                case (w_opcode)
                    OP_RTYPE:       w_next = w_funct_ok ? S_EX_R : S_IF;
                    OP_LW, OP_SW:   w_next = S_MEM_ADDR;
                    OP_BEQ:         w_next = S_EX_BEQ;
                    OP_J:           w_next = S_EX_J;
                    OP_ADDI, OP_SLTI: w_next = S_EX_I;
                    default:        w_next = S_IF;
                endcase
            end
            S_EX_R:     w_next = S_WB_R;
            S_WB_R:     w_next = S_IF;
            S_MEM_ADDR: w_next = (w_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next = bus.MIO_ready ? S_WB_LW : S_MEM_RD;
            S_WB_LW:    w_next = S_IF;
            S_MEM_WR:   w_next = bus.MIO_ready ? S_IF : S_MEM_WR;
            S_EX_BEQ:   w_next = S_IF;
            S_EX_J:     w_next = S_IF;
            S_EX_I:     w_next = S_WB_I;
            S_WB_I:     w_next = S_IF;
            default:    w_next = S_IF;
        endcase
    end

    // Outputs are the decode of the state being entered, registered alongside it.
    // Inst is held by the IR from ID onward, so the funct/opcode-dependent ALU code
    // captured on entry to EX_R/EX_I matches a live decode of Inst in that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IF;
            r_out   <= ctrl_decode(S_IF, ALU_ADD, 1'b0);
        end else begin
            r_state <= w_next;
            r_out   <= ctrl_decode(w_next, w_alu_code, w_is_slti);
        end
    end

    assign bus.state         = r_state;
    assign bus.IorD          = r_out.IorD;
    assign bus.IRWrite       = r_out.IRWrite;
    assign bus.RegDst        = r_out.RegDst;
    assign bus.RegWrite      = r_out.RegWrite;
    assign bus.MemtoReg      = r_out.MemtoReg;
    assign bus.ALUSrcA       = r_out.ALUSrcA;
    assign bus.ALUSrcB       = r_out.ALUSrcB;
    assign bus.PCSource      = r_out.PCSource;
    assign bus.PCWrite       = r_out.PCWrite;
    assign bus.PCWriteCond   = r_out.PCWriteCond;
    assign bus.Branch        = r_out.Branch;
    assign bus.ALU_operation = r_out.ALU_operation;
    assign bus.MemRW         = r_out.MemRW;
    assign bus.CPU_MIO       = r_out.CPU_MIO;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: per-cycle expected state and outputs.
module tb_multi_cycle_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_cycle_ctrl_if bus();

    multi_cycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  st;
        logic        mio;
        logic [19:0] outs;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [19:0] obs_outs();
        return {bus.IorD, bus.IRWrite, bus.RegDst, bus.RegWrite, bus.MemtoReg,
                bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.PCWrite, bus.PCWriteCond,
                bus.Branch, bus.ALU_operation, bus.MemRW, bus.CPU_MIO};
    endfunction

    // {valid, alu code} for an R-type funct
    function automatic logic [3:0] funct_info(input logic [5:0] f);
        case (f)
            6'b100000: return {1'b1, 3'b010};
            6'b100010: return {1'b1, 3'b110};
            6'b100100: return {1'b1, 3'b000};
            6'b100101: return {1'b1, 3'b001};
            6'b100110: return {1'b1, 3'b011};
            6'b100111: return {1'b1, 3'b100};
            6'b101010: return {1'b1, 3'b111};
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic logic [19:0] model_outs(input logic [3:0] st, input logic [31:0] inst);
        logic iord, irw, rw, asa, pcw, pcwc, br, memrw, mio;
        logic [1:0] rd, m2r, asb, pcs;
        logic [2:0] alu;
        logic [3:0] fi;
        {iord, irw, rw, asa, pcw, pcwc, br, memrw, mio} = '0;
        {rd, m2r, asb, pcs} = '0;
        alu = 3'b000;
        fi = funct_info(inst[5:0]);
        case (st)
            4'd0:  begin mio = 1'b1; irw = 1'b1; asb = 2'b01; alu = 3'b010; pcw = 1'b1; end
            4'd1:  begin asb = 2'b11; alu = 3'b010; end
            4'd2:  begin asa = 1'b1; asb = 2'b10; alu = 3'b010; end
            4'd3:  begin mio = 1'b1; iord = 1'b1; end
            4'd4:  begin m2r = 2'b01; rw = 1'b1; end
            4'd5:  begin mio = 1'b1; iord = 1'b1; memrw = 1'b1; end
            4'd6:  begin asa = 1'b1; alu = fi[2:0]; end
            4'd7:  begin rd = 2'b01; rw = 1'b1; end
            4'd8:  begin asa = 1'b1; alu = 3'b110; pcwc = 1'b1; br = 1'b1; pcs = 2'b01; end
            4'd9:  begin pcs = 2'b10; pcw = 1'b1; end
            4'd10: begin asa = 1'b1; asb = 2'b10; alu = (inst[31:26] == 6'b001010) ? 3'b111 : 3'b010; end
            4'd11: begin rw = 1'b1; end
            default: ;
        endcase
        return {iord, irw, rd, rw, m2r, asa, asb, pcs, pcw, pcwc, br, alu, memrw, mio};
    endfunction

    task automatic push(input logic [3:0] st, input logic mio, input logic [31:0] inst);
        exp_t e;
        e.st = st;
        e.mio = mio;
        e.outs = model_outs(st, inst);
        sb.push_back(e);
    endtask

    // Entered at posedge+1 with the DUT in IF; leaves at posedge+1 back in IF.
    task automatic run_instr(input logic [31:0] inst, input logic z, input int unsigned if_stall,
                             input int unsigned mem_stall, input string name);
        logic [5:0] op;
        logic [3:0] fi;
        exp_t e;
        op = inst[31:26];
        fi = funct_info(inst[5:0]);
        bus.Inst = inst;
        bus.zero = z;
        for (int unsigned i = 0; i < if_stall; i++) push(4'd0, 1'b0, inst);
        push(4'd0, 1'b1, inst);
        push(4'd1, 1'b1, inst);
        case (op)
            6'b000000: if (fi[3]) begin push(4'd6, 1'b1, inst); push(4'd7, 1'b1, inst); end
            6'b100011: begin
                push(4'd2, 1'b1, inst);
                for (int unsigned i = 0; i < mem_stall; i++) push(4'd3, 1'b0, inst);
                push(4'd3, 1'b1, inst);
                push(4'd4, 1'b1, inst);
            end
            6'b101011: begin
                push(4'd2, 1'b1, inst);
                for (int unsigned i = 0; i < mem_stall; i++) push(4'd5, 1'b0, inst);
                push(4'd5, 1'b1, inst);
            end
            6'b000100: push(4'd8, 1'b1, inst);
            6'b000010: push(4'd9, 1'b1, inst);
            6'b001000, 6'b001010: begin push(4'd10, 1'b1, inst); push(4'd11, 1'b1, inst); end
            default: ;
        endcase
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.MIO_ready = e.mio;
            @(negedge clk);
            check_eq({name, " state"}, 32'(bus.state), 32'(e.st));
            check_eq({name, " outs"}, 32'(obs_outs()), 32'(e.outs));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.Inst = '0;
        bus.zero = 1'b0;
        bus.MIO_ready = 1'b0;
        #12;
        check_eq("reset state", 32'(bus.state), 32'd0);
        check_eq("reset outs", 32'(obs_outs()), 32'(model_outs(4'd0, 32'd0)));
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset while waiting in MEM_RD
        bus.Inst = 32'h8C220004;
        bus.MIO_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.MIO_ready = 1'b0;
        check_eq("pre-reset mem_rd", 32'(bus.state), 32'd3);
        #2 reset = 1'b1;
        #1;
        check_eq("async reset state", 32'(bus.state), 32'd0);
        check_eq("async reset IorD", 32'(bus.IorD), 32'd0);
        check_eq("async reset IRWrite", 32'(bus.IRWrite), 32'd1);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset while a store is stalled in MEM_WR
        bus.Inst = 32'hAC220008;
        bus.MIO_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.MIO_ready = 1'b0;
        check_eq("pre-reset mem_wr MemRW", 32'(bus.MemRW), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("async reset MemRW", 32'(bus.MemRW), 32'd0);
        check_eq("async reset outs", 32'(obs_outs()), 32'(model_outs(4'd0, 32'd0)));
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        run_instr(32'h8C220004, 1'b0, 0, 2, "lw_stall");
        run_instr(32'h8C220004, 1'b0, 0, 0, "lw");
        run_instr(32'h00221820, 1'b0, 0, 0, "add");
        run_instr(32'h00221820, 1'b0, 2, 0, "add_ifstall");
        run_instr(32'h00221822, 1'b0, 0, 0, "sub");
        run_instr(32'h00221824, 1'b0, 0, 0, "and");
        run_instr(32'h00221825, 1'b0, 0, 0, "or");
        run_instr(32'h00221826, 1'b0, 0, 0, "xor");
        run_instr(32'h00221827, 1'b0, 0, 0, "nor");
        run_instr(32'h0022182A, 1'b0, 0, 0, "slt");
        run_instr(32'h00221821, 1'b0, 0, 0, "r_badfunct");
        run_instr(32'h10220003, 1'b1, 0, 0, "beq_z1");
        run_instr(32'h10220003, 1'b0, 0, 0, "beq_z0");
        run_instr(32'h08000010, 1'b0, 0, 0, "j");
        run_instr(32'hFC000000, 1'b0, 0, 0, "unknown");
        run_instr(32'hAC220008, 1'b0, 0, 0, "sw");
        run_instr(32'hAC220008, 1'b0, 0, 1, "sw_stall");
        run_instr(32'h2841FFFF, 1'b0, 0, 0, "slti");
        run_instr(32'h2041FFFF, 1'b0, 0, 0, "addi");

        bus.MIO_ready = 1'b0;
        @(negedge clk);
        check_eq("final state", 32'(bus.state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
